// File: rtl/shared_reg_ctrl_if.sv
// Client/register bundle for shared_reg_ctrl.
// REQ_LOCK exists only when SHARED_REG_CTRL_LOCK_EN is defined.
interface shared_reg_ctrl_if #(
    parameter int C_WIDTH   = 16,
    parameter int C_NUM_REQ = 4
);
    logic [C_NUM_REQ-1:0]         REQ;
    logic [2*C_NUM_REQ-1:0]       REQ_OP;
    logic [C_WIDTH*C_NUM_REQ-1:0] REQ_D;
`ifdef SHARED_REG_CTRL_LOCK_EN
    logic [C_NUM_REQ-1:0]         REQ_LOCK;
`endif
    logic [C_NUM_REQ-1:0]         GNT;
    logic                         ACK;
    logic                         BUSY;
    logic                         INIT_DONE;
    logic [C_WIDTH-1:0]           REG_D;
    logic                         REG_CE;
    logic                         REG_SCLR;
    logic                         REG_SSET;
    logic                         REG_SINIT;
    logic [C_WIDTH-1:0]           SHADOW_Q;

`ifdef SHARED_REG_CTRL_LOCK_EN
    modport master (
        output REQ, REQ_OP, REQ_D, REQ_LOCK,
        input  GNT, ACK, BUSY, INIT_DONE,
        input  REG_D, REG_CE, REG_SCLR, REG_SSET, REG_SINIT,
        input  SHADOW_Q
    );
    modport slave (
        input  REQ, REQ_OP, REQ_D, REQ_LOCK,
        output GNT, ACK, BUSY, INIT_DONE,
        output REG_D, REG_CE, REG_SCLR, REG_SSET, REG_SINIT,
        output SHADOW_Q
    );
`else
    modport master (
        output REQ, REQ_OP, REQ_D,
        input  GNT, ACK, BUSY, INIT_DONE,
        input  REG_D, REG_CE, REG_SCLR, REG_SSET, REG_SINIT,
        input  SHADOW_Q
    );
    modport slave (
        input  REQ, REQ_OP, REQ_D,
        output GNT, ACK, BUSY, INIT_DONE,
        output REG_D, REG_CE, REG_SCLR, REG_SSET, REG_SINIT,
        output SHADOW_Q
    );
`endif
endinterface

// File: rtl/shared_reg_ctrl.sv
// Round-robin controller sharing one D/CE/SCLR/SSET/SINIT register.
// Optional grantee lock: define SHARED_REG_CTRL_LOCK_EN.
module shared_reg_ctrl #(
    parameter int               C_WIDTH       = 16,
    parameter int               C_NUM_REQ     = 4,
    parameter logic [C_WIDTH-1:0] C_SINIT_VAL = '0,
    parameter int               C_INIT_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             ACLR,
    shared_reg_ctrl_if.slave bus
);
    localparam int         PW     = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
    localparam logic [3:0] INIT_N = 4'(C_INIT_CYCLES);
    localparam logic [PW-1:0] LAST = PW'(C_NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [3:0]           cnt_q;
    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        gidx_q;
    logic [1:0]           op_q;
    logic [C_WIDTH-1:0]   data_q;
    logic [C_WIDTH-1:0]   shadow_q;
    logic [C_NUM_REQ-1:0] gnt_q;
    logic                 ack_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ce_q;
    logic                 sclr_q;
    logic                 sset_q;
    logic                 sinit_q;

    logic [1:0]         op_a [C_NUM_REQ];
    logic [C_WIDTH-1:0] d_a  [C_NUM_REQ];

    for (genvar g = 0; g < C_NUM_REQ; g++) begin : g_slice
        assign op_a[g] = bus.REQ_OP[2*g +: 2];
        assign d_a[g]  = bus.REQ_D[C_WIDTH*g +: C_WIDTH];
    end

    // First requester at or above the pointer, wrapping around
    logic          win_vld;
    logic [PW-1:0] win_idx;

    always_comb begin
        logic [PW:0] sum;
        win_vld = 1'b0;
        win_idx = '0;
        sum     = '0;
        for (int k = 0; k < C_NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(C_NUM_REQ)) begin
                sum = sum - (PW+1)'(C_NUM_REQ);
            end
            if (!win_vld && bus.REQ[sum[PW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = sum[PW-1:0];
            end
        end
    end

    logic lock_hold;
`ifdef SHARED_REG_CTRL_LOCK_EN
    assign lock_hold = bus.REQ_LOCK[gidx_q] & bus.REQ[gidx_q];
`else
    assign lock_hold = 1'b0;
`endif

    logic [C_WIDTH-1:0] shadow_nxt;
    always_comb begin
        shadow_nxt = shadow_q;
        unique case (op_q)
            2'b00: shadow_nxt = data_q;
            2'b01: shadow_nxt = '0;
            2'b10: shadow_nxt = '1;
            2'b11: shadow_nxt = C_SINIT_VAL;
        endcase
    end

    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            ptr_q    <= '0;
            gidx_q   <= '0;
            op_q     <= '0;
            data_q   <= '0;
            shadow_q <= '0;
            gnt_q    <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            ce_q     <= 1'b0;
            sclr_q   <= 1'b0;
            sset_q   <= 1'b0;
            sinit_q  <= 1'b0;
        end else begin
            ce_q    <= 1'b0;
            sclr_q  <= 1'b0;
            sset_q  <= 1'b0;
            sinit_q <= 1'b0;
            ack_q   <= 1'b0;
            unique case (state_q)
                S_INIT: begin
                    if (cnt_q < INIT_N) begin
                        sinit_q <= 1'b1;
                        cnt_q   <= cnt_q + 4'd1;
                    end else begin
                        shadow_q <= C_SINIT_VAL;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (win_vld) begin
                        gnt_q   <= {{(C_NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                        gidx_q  <= win_idx;
                        op_q    <= op_a[win_idx];
                        data_q  <= d_a[win_idx];
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                S_ISSUE: begin
                    unique case (op_q)
                        2'b00: ce_q    <= 1'b1;
                        2'b01: sclr_q  <= 1'b1;
                        2'b10: sset_q  <= 1'b1;
                        2'b11: sinit_q <= 1'b1;
                    endcase
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    ack_q    <= 1'b1;
                    shadow_q <= shadow_nxt;
                    // A locked grantee goes straight back to ISSUE with fresh op/data
                    if (lock_hold) begin
                        op_q    <= op_a[gidx_q];
                        data_q  <= d_a[gidx_q];
                        state_q <= S_ISSUE;
                    end else begin
                        ptr_q   <= (gidx_q == LAST) ? '0 : gidx_q + PW'(1);
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.GNT       = gnt_q;
    assign bus.ACK       = ack_q;
    assign bus.BUSY      = busy_q;
    assign bus.INIT_DONE = done_q;
    assign bus.REG_D     = data_q;
    assign bus.REG_CE    = ce_q;
    assign bus.REG_SCLR  = sclr_q;
    assign bus.REG_SSET  = sset_q;
    assign bus.REG_SINIT = sinit_q;
    assign bus.SHADOW_Q  = shadow_q;

endmodule

// File: tb/tb_shared_reg_ctrl.sv
// Directed-vector bench for shared_reg_ctrl (SINIT value 16'h00A5, 2 init cycles).
// Lock scenario runs only when SHARED_REG_CTRL_LOCK_EN is defined.
module tb_shared_reg_ctrl;
    localparam int W = 16;
    localparam int N = 4;

    logic CLK;
    logic ACLR;
    int   nvec;
    int   nerr;

    shared_reg_ctrl_if #(.C_WIDTH(W), .C_NUM_REQ(N)) bus ();

    shared_reg_ctrl #(
        .C_WIDTH      (W),
        .C_NUM_REQ    (N),
        .C_SINIT_VAL  (16'h00A5),
        .C_INIT_CYCLES(2)
    ) dut (
        .CLK (CLK),
        .ACLR(ACLR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [3:0] s;
        @(negedge CLK);
        s = {bus.REG_CE, bus.REG_SCLR, bus.REG_SSET, bus.REG_SINIT};
        chk("strobe_excl", 32'($countones(s) <= 1), 32'd1);
    endtask

    task automatic init_seq(input string tag);
        tick();
        chk({tag, "_sinit1"}, 32'(bus.REG_SINIT), 32'd1);
        chk({tag, "_gnt1"}, 32'(bus.GNT), 32'd0);
        tick();
        chk({tag, "_sinit2"}, 32'(bus.REG_SINIT), 32'd1);
        chk({tag, "_done2"}, 32'(bus.INIT_DONE), 32'd0);
        tick();
        chk({tag, "_sinit3"}, 32'(bus.REG_SINIT), 32'd0);
        chk({tag, "_done3"}, 32'(bus.INIT_DONE), 32'd1);
        chk({tag, "_shadow"}, 32'(bus.SHADOW_Q), 32'h00A5);
        chk({tag, "_gnt3"}, 32'(bus.GNT), 32'd0);
    endtask

    initial begin
        nvec   = 0;
        nerr   = 0;
        ACLR   = 1'b1;
        bus.REQ    = 4'b0001;
        bus.REQ_OP = '0;
        bus.REQ_D  = '0;
`ifdef SHARED_REG_CTRL_LOCK_EN
        bus.REQ_LOCK = '0;
`endif
        tick();
        chk("rst_gnt", 32'(bus.GNT), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd1);
        chk("rst_done", 32'(bus.INIT_DONE), 32'd0);
        chk("rst_sinit", 32'(bus.REG_SINIT), 32'd0);
        chk("rst_shadow", 32'(bus.SHADOW_Q), 32'd0);
        ACLR = 1'b0;

        init_seq("init");
        bus.REQ = '0;
        tick();
        chk("idle_gnt", 32'(bus.GNT), 32'd0);
        chk("idle_busy", 32'(bus.BUSY), 32'd0);

        // all four clear, grant order 0,1,2,3,0
        bus.REQ    = 4'b1111;
        bus.REQ_OP = 8'b01_01_01_01;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] eg;
            eg = 4'b0001 << (k % 4);
            tick();
            chk("rr_gnt", 32'(bus.GNT), 32'(eg));
            chk("rr_sclr_pre", 32'(bus.REG_SCLR), 32'd0);
            tick();
            chk("rr_sclr", 32'(bus.REG_SCLR), 32'd1);
            tick();
            chk("rr_ack", 32'(bus.ACK), 32'd1);
            chk("rr_shadow", 32'(bus.SHADOW_Q), 32'd0);
            if (k == 4) bus.REQ = '0;
        end
        tick();
        chk("rr_end_gnt", 32'(bus.GNT), 32'd0);
        chk("rr_end_ack", 32'(bus.ACK), 32'd0);

        // load 16'h1234 from requester 1
        bus.REQ        = 4'b0010;
        bus.REQ_OP     = '0;
        bus.REQ_D[31:16] = 16'h1234;
        tick();
        chk("ld_gnt", 32'(bus.GNT), 32'b0010);
        chk("ld_busy", 32'(bus.BUSY), 32'd1);
        tick();
        chk("ld_ce", 32'(bus.REG_CE), 32'd1);
        chk("ld_d", 32'(bus.REG_D), 32'h1234);
        chk("ld_ack0", 32'(bus.ACK), 32'd0);
        tick();
        chk("ld_ack", 32'(bus.ACK), 32'd1);
        chk("ld_ce0", 32'(bus.REG_CE), 32'd0);
        chk("ld_shadow", 32'(bus.SHADOW_Q), 32'h1234);
        bus.REQ = '0;
        tick();
        chk("ld_gnt0", 32'(bus.GNT), 32'd0);

        // set from requester 2, request dropped after grant
        bus.REQ        = 4'b0100;
        bus.REQ_OP[5:4] = 2'b10;
        tick();
        chk("set_gnt", 32'(bus.GNT), 32'b0100);
        bus.REQ = '0;
        tick();
        chk("set_sset", 32'(bus.REG_SSET), 32'd1);
        tick();
        chk("set_ack", 32'(bus.ACK), 32'd1);
        chk("set_shadow", 32'(bus.SHADOW_Q), 32'hFFFF);
        tick();
        chk("set_gnt0", 32'(bus.GNT), 32'd0);

        // reset in the middle of a load of 16'hBEEF
        bus.REQ          = 4'b1000;
        bus.REQ_OP[7:6]  = 2'b00;
        bus.REQ_D[63:48] = 16'hBEEF;
        tick();
        chk("ar_gnt", 32'(bus.GNT), 32'b1000);
        tick();
        chk("ar_ce", 32'(bus.REG_CE), 32'd1);
        chk("ar_d", 32'(bus.REG_D), 32'hBEEF);
        #2 ACLR = 1'b1;
        #1;
        chk("ar_ce0", 32'(bus.REG_CE), 32'd0);
        chk("ar_gnt0", 32'(bus.GNT), 32'd0);
        chk("ar_ack0", 32'(bus.ACK), 32'd0);
        chk("ar_shadow", 32'(bus.SHADOW_Q), 32'd0);
        chk("ar_done0", 32'(bus.INIT_DONE), 32'd0);
        bus.REQ = '0;
        tick();
        chk("ar_ack_hold", 32'(bus.ACK), 32'd0);
        ACLR = 1'b0;
        init_seq("reinit");

`ifdef SHARED_REG_CTRL_LOCK_EN
        // locked requester 3 issues three loads while requester 0 waits
        bus.REQ          = 4'b1000;
        bus.REQ_LOCK     = 4'b1000;
        bus.REQ_OP       = 8'b00_00_00_01;
        bus.REQ_D[63:48] = 16'd1;
        tick();
        chk("lk_gnt", 32'(bus.GNT), 32'b1000);
        bus.REQ = 4'b1001;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("lk_ce", 32'(bus.REG_CE), 32'd1);
            chk("lk_d", 32'(bus.REG_D), 32'(k));
            chk("lk_gnt_hold", 32'(bus.GNT), 32'b1000);
            if (k < 3) begin
                bus.REQ_D[63:48] = 16'(k + 1);
            end else begin
                bus.REQ_LOCK = '0;
                bus.REQ      = 4'b0001;
            end
            tick();
            chk("lk_ack", 32'(bus.ACK), 32'd1);
            chk("lk_shadow", 32'(bus.SHADOW_Q), 32'(k));
            chk("lk_ce0", 32'(bus.REG_CE), 32'd0);
        end
        tick();
        chk("lk_gnt0", 32'(bus.GNT), 32'b0001);
        tick();
        chk("lk_sclr0", 32'(bus.REG_SCLR), 32'd1);
        tick();
        chk("lk_ack0", 32'(bus.ACK), 32'd1);
        bus.REQ = '0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
